// File: rtl/mem_walker_stride_mc_pkg.sv
// Shared types for the multi-channel stride walker: FSM states, err_status bit map, event bundle.
// Optional bound checking is enabled with `define MEM_WALKER_BOUND_CHECK_EN.
package mem_walker_stride_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CFG   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } walker_state_e;

    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_CFG_BIT = 1;
    localparam int ERR_BND_LSB = 2;

    // Decoded, priority-resolved loop events broadcast to every channel.
    typedef struct packed {
        logic init;
        logic idx;
        logic enter;
    } walker_ev_t;

endpackage

// File: rtl/mem_walker_stride_ch.sv
// One address channel: stride table, per-level checkpoints, running address and window check.
// Window check is built only when MEM_WALKER_BOUND_CHECK_EN is defined.
module mem_walker_stride_ch
    import mem_walker_stride_mc_pkg::*;
#(
    parameter int ADDR_WIDTH    = 48,
    parameter int ADDR_STRIDE_W = 16,
    parameter int LOOP_ID_W     = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we_i,
    input  logic [ADDR_STRIDE_W-1:0] cfg_stride_i,
    input  logic                     wrptr_clr_i,
    input  walker_ev_t               ev_i,
    input  logic [LOOP_ID_W-1:0]     level_i,
    input  logic [ADDR_WIDTH-1:0]    base_i,
    input  logic [ADDR_WIDTH-1:0]    limit_i,
    output logic [LOOP_ID_W-1:0]     wrptr_o,
    output logic [ADDR_WIDTH-1:0]    addr_o,
    output logic                     oob_o
);
    localparam int NLEV = 2**LOOP_ID_W;

    logic [ADDR_STRIDE_W-1:0] stride_q [NLEV];
    logic [ADDR_WIDTH-1:0]    cp_q     [NLEV];
    logic [NLEV-1:0]          cp_vld_q;
    logic [LOOP_ID_W-1:0]     wrptr_q;
    logic [ADDR_WIDTH-1:0]    addr_q, cp_rd, nxt_d;

    // A level never entered since init restarts from the running address.
    assign cp_rd = cp_vld_q[level_i] ? cp_q[level_i] : addr_q;
    assign nxt_d = cp_rd + {{(ADDR_WIDTH-ADDR_STRIDE_W){stride_q[level_i][ADDR_STRIDE_W-1]}},
                            stride_q[level_i]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrptr_q  <= '0;
            cp_vld_q <= '0;
            addr_q   <= '0;
        end else begin
            if (wrptr_clr_i)   wrptr_q <= '0;
            else if (cfg_we_i) wrptr_q <= wrptr_q + 1'b1;

            if (ev_i.init) begin
                addr_q   <= base_i;
                cp_vld_q <= '0;
            end else if (ev_i.idx) begin
                addr_q            <= nxt_d;
                cp_vld_q[level_i] <= 1'b1;
            end else if (ev_i.enter) begin
                cp_vld_q[level_i] <= 1'b1;
            end
        end
    end

    // Table contents are qualified by wrptr/valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        if (cfg_we_i) stride_q[wrptr_q] <= cfg_stride_i;
        if (!ev_i.init) begin
            if (ev_i.idx)        cp_q[level_i] <= nxt_d;
            else if (ev_i.enter) cp_q[level_i] <= addr_q;
        end
    end

    assign wrptr_o = wrptr_q;
    assign addr_o  = addr_q;

`ifdef MEM_WALKER_BOUND_CHECK_EN
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   win_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          base_q <= '0;
        else if (ev_i.init) base_q <= base_i;
    end

    // One extra bit so a window ending past the top of the space does not wrap.
    assign win_end = {1'b0, base_q} + {1'b0, limit_i};
    assign oob_o   = (addr_q < base_q) || ({1'b0, addr_q} >= win_end);
`else
    logic unused_limit;
    assign unused_limit = ^limit_i;
    assign oob_o        = 1'b0;
`endif

endmodule

// File: rtl/mem_walker_stride_mc.sv
// Multi-channel nested-loop address generator: FSM, innermost-level tracking, output FIFO and stall.
// Define MEM_WALKER_BOUND_CHECK_EN to enable the per-channel window check (err_bound bits).
module mem_walker_stride_mc
    import mem_walker_stride_mc_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int ADDR_WIDTH     = 48,
    parameter int ADDR_STRIDE_W  = 16,
    parameter int LOOP_ID_W      = 5,
    parameter int OUT_FIFO_DEPTH = 8,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] base_addr,
    input  logic                         loop_init,
    input  logic                         loop_enter,
    input  logic                         loop_index_valid,
    input  logic [LOOP_ID_W-1:0]         loop_index,
    input  logic                         loop_ctrl_done,
    output logic                         loop_stall,
    input  logic                         cfg_addr_stride_v,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [ADDR_STRIDE_W-1:0]     cfg_addr_stride,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_addr_limit,
    output logic [NUM_CH*ADDR_WIDTH-1:0] addr_out,
    output logic                         addr_out_valid,
    input  logic                         addr_out_ready,
    output logic                         busy,
    output logic [NUM_CH+1:0]            err_status
);
    localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [NUM_CH-1:0][ADDR_WIDTH-1:0] entry_t;

    walker_state_e                   state_q, state_d;
    logic [LOOP_ID_W-1:0]            inner_q;
    logic [NUM_CH-1:0][LOOP_ID_W-1:0] ch_wrptr;
    entry_t                          ch_addr;
    logic [NUM_CH-1:0]               ch_oob, cfg_we;
    walker_ev_t                      ev;
    logic                            cfg_open, wrptr_clr, push_req, do_push, pop, full;
    entry_t                          fifo_q [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            stall_q, err_ovf_q, err_cfg_q;
    logic [NUM_CH-1:0]               err_bnd_q;
    logic                            unused_wrptr;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (loop_init) state_d = ST_RUN;
                      else if (cfg_addr_stride_v) state_d = ST_CFG;
            ST_CFG:   if (loop_init) state_d = ST_RUN;
            ST_RUN:   if (loop_ctrl_done) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign cfg_open  = (state_q == ST_IDLE) || (state_q == ST_CFG);
    assign wrptr_clr = (state_q != ST_IDLE) && (state_d == ST_IDLE);

    // init beats index_valid beats enter; only init is honoured before RUN.
    always_comb begin
        ev.init  = loop_init && (state_q != ST_DRAIN);
        ev.idx   = (state_q == ST_RUN) && !loop_init && loop_index_valid;
        ev.enter = (state_q == ST_RUN) && !loop_init && !loop_index_valid && loop_enter;
    end

    assign push_req = ev.idx && (loop_index == inner_q);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign cfg_we[c] = cfg_addr_stride_v && cfg_open && (cfg_ch == CH_W'(c));

        mem_walker_stride_ch #(
            .ADDR_WIDTH   (ADDR_WIDTH),
            .ADDR_STRIDE_W(ADDR_STRIDE_W),
            .LOOP_ID_W    (LOOP_ID_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .cfg_we_i    (cfg_we[c]),
            .cfg_stride_i(cfg_addr_stride),
            .wrptr_clr_i (wrptr_clr),
            .ev_i        (ev),
            .level_i     (loop_index),
            .base_i      (base_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .limit_i     (cfg_addr_limit[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .wrptr_o     (ch_wrptr[c]),
            .addr_o      (ch_addr[c]),
            .oob_o       (ch_oob[c])
        );
    end

    // Only channel 0's write pointer defines the innermost level.
    assign unused_wrptr = ^ch_wrptr;

    always_comb begin
        pop     = (cnt_q != '0) && addr_out_ready;
        full    = (cnt_q == CNT_W'(OUT_FIFO_DEPTH));
        do_push = push_req && (!full || pop);
        cnt_d   = cnt_q;
        if (do_push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            inner_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            err_ovf_q <= 1'b0;
            err_cfg_q <= 1'b0;
            err_bnd_q <= '0;
        end else begin
            state_q <= state_d;
            if (ev.init) inner_q <= ch_wrptr[0] - 1'b1;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
            // Raised two entries early so a controller reacting a cycle late cannot overflow.
            stall_q <= (cnt_d >= CNT_W'(OUT_FIFO_DEPTH-2));
            if (push_req && !do_push)               err_ovf_q <= 1'b1;
            if (cfg_addr_stride_v && !cfg_open)     err_cfg_q <= 1'b1;
            err_bnd_q <= err_bnd_q | (ch_oob & {NUM_CH{push_req}});
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) fifo_q[wr_ptr_q] <= ch_addr;
    end

    assign addr_out_valid = (cnt_q != '0);
    assign addr_out       = addr_out_valid ? fifo_q[rd_ptr_q] : '0;
    assign loop_stall     = stall_q;
    assign busy           = (state_q != ST_IDLE);

    assign err_status[ERR_OVF_BIT]           = err_ovf_q;
    assign err_status[ERR_CFG_BIT]           = err_cfg_q;
    assign err_status[ERR_BND_LSB +: NUM_CH] = err_bnd_q;

endmodule

// File: tb/tb_mem_walker_stride_mc.sv
// Bench for mem_walker_stride_mc: queue-based reference model, per-cycle compare, directed + random nests.
module tb_mem_walker_stride_mc;
    localparam int NCH = 4, AW = 48, SW = 16, LW = 5, NLEV = 32, DEP = 8;
    localparam longint unsigned MASK = 64'h0000_FFFF_FFFF_FFFF;
    typedef logic [NCH*AW-1:0] ent_t;

    logic              clk = 1'b0, reset = 1'b1;
    logic [NCH*AW-1:0] base_addr = '0, cfg_addr_limit = '1;
    logic              loop_init = 0, loop_enter = 0, loop_index_valid = 0, loop_ctrl_done = 0;
    logic [LW-1:0]     loop_index = '0;
    logic              loop_stall, cfg_addr_stride_v = 0, addr_out_valid, addr_out_ready = 0, busy;
    logic [1:0]        cfg_ch = '0;
    logic [SW-1:0]     cfg_addr_stride = '0;
    logic [NCH*AW-1:0] addr_out;
    logic [NCH+1:0]    err_status;

    mem_walker_stride_mc dut (
        .clk(clk), .reset(reset), .base_addr(base_addr), .loop_init(loop_init),
        .loop_enter(loop_enter), .loop_index_valid(loop_index_valid), .loop_index(loop_index),
        .loop_ctrl_done(loop_ctrl_done), .loop_stall(loop_stall),
        .cfg_addr_stride_v(cfg_addr_stride_v), .cfg_ch(cfg_ch), .cfg_addr_stride(cfg_addr_stride),
        .cfg_addr_limit(cfg_addr_limit), .addr_out(addr_out), .addr_out_valid(addr_out_valid),
        .addr_out_ready(addr_out_ready), .busy(busy), .err_status(err_status)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit chk_on = 0;

    // Reference model: mode 0 idle, 1 cfg, 2 run, 3 drain.
    ent_t            mq[$];
    longint unsigned m_addr[NCH], m_base[NCH], m_cp[NCH][NLEV];
    bit              m_cpv[NCH][NLEV];
    int              m_str[NCH][NLEV];
    int              m_wp[NCH];
    int              m_inner, m_st;
    bit              m_ovf, m_cfg;
    bit [NCH-1:0]    m_bnd;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_st = 0; m_inner = 0; m_ovf = 0; m_cfg = 0; m_bnd = '0;
        for (int c = 0; c < NCH; c++) begin
            m_wp[c] = 0; m_addr[c] = 0; m_base[c] = 0;
            for (int l = 0; l < NLEV; l++) m_cpv[c][l] = 0;
        end
    endtask

    task automatic model_step();
        bit pop, push_try;
        int wp0, L, pre_sz;
        longint unsigned src, lim;
        ent_t e;
        pre_sz = mq.size();
        pop = (pre_sz != 0) && addr_out_ready;
        wp0 = m_wp[0];
        L = int'(loop_index);
        push_try = 0;
        e = '0;
        if (cfg_addr_stride_v) begin
            if (m_st <= 1) begin
                m_str[cfg_ch][m_wp[cfg_ch]] = int'($signed(cfg_addr_stride));
                m_wp[cfg_ch] = (m_wp[cfg_ch] + 1) % NLEV;
            end else m_cfg = 1;
        end
        if (loop_init && m_st != 3) begin
            for (int c = 0; c < NCH; c++) begin
                m_addr[c] = base_addr[c*AW +: AW];
                m_base[c] = m_addr[c];
                for (int l = 0; l < NLEV; l++) m_cpv[c][l] = 0;
            end
            m_inner = (wp0 + NLEV - 1) % NLEV;
        end else if (m_st == 2 && loop_index_valid) begin
            if (L == m_inner) begin
                push_try = 1;
                for (int c = 0; c < NCH; c++) begin
                    e[c*AW +: AW] = m_addr[c][AW-1:0];
                    lim = cfg_addr_limit[c*AW +: AW];
`ifdef MEM_WALKER_BOUND_CHECK_EN
                    if (m_addr[c] < m_base[c] || m_addr[c] >= m_base[c] + lim) m_bnd[c] = 1;
`endif
                end
            end
            for (int c = 0; c < NCH; c++) begin
                src = m_cpv[c][L] ? m_cp[c][L] : m_addr[c];
                m_addr[c] = (src + 64'(longint'(m_str[c][L]))) & MASK;
                m_cp[c][L] = m_addr[c];
                m_cpv[c][L] = 1;
            end
        end else if (m_st == 2 && loop_enter) begin
            for (int c = 0; c < NCH; c++) begin
                m_cp[c][L] = m_addr[c];
                m_cpv[c][L] = 1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push_try) begin
            if (pre_sz < DEP || pop) mq.push_back(e);
            else m_ovf = 1;
        end
        case (m_st)
            0: if (loop_init) m_st = 2; else if (cfg_addr_stride_v) m_st = 1;
            1: if (loop_init) m_st = 2;
            2: if (loop_ctrl_done) m_st = 3;
            default: if (pre_sz == 0) begin
                m_st = 0;
                for (int c = 0; c < NCH; c++) m_wp[c] = 0;
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            chk("valid", addr_out_valid, mq.size() != 0);
            if (mq.size() != 0) chk("head", addr_out, mq[0]);
            chk("stall", loop_stall, mq.size() >= DEP - 2);
            chk("busy", busy, m_st != 0);
            chk("err", err_status, {m_bnd, m_cfg, m_ovf});
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cfg_wr(input int ch, input int s);
        cfg_addr_stride_v = 1; cfg_ch = 2'(ch); cfg_addr_stride = 16'(s);
        tick();
        cfg_addr_stride_v = 0;
    endtask

    task automatic ev(input bit ini, input bit ent, input bit idx, input int lvl);
        loop_init = ini; loop_enter = ent; loop_index_valid = idx; loop_index = LW'(lvl);
        tick();
        loop_init = 0; loop_enter = 0; loop_index_valid = 0;
    endtask

    task automatic finish_nest();
        loop_ctrl_done = 1;
        tick();
        loop_ctrl_done = 0;
        addr_out_ready = 1;
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("drain_idle", busy, 0);
    endtask

    task automatic set_base(input int ch, input longint unsigned b);
        base_addr[ch*AW +: AW] = AW'(b);
    endtask

    longint unsigned t1[6] = '{1000, 1004, 1008, 1100, 1104, 1108};
    longint unsigned t2[4] = '{64'h10, 64'h08, 64'h00, 64'hFFFF_FFFF_FFF8};

    initial begin
        m_reset();
        #2;
        chk("rst_valid", addr_out_valid, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_stall", loop_stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_status, 0);
        @(posedge clk); #1;
        reset = 0;
        chk_on = 1;

        // Two-level nest on ch0.
        cfg_wr(0, 100); cfg_wr(0, 4);
        for (int c = 1; c < NCH; c++) begin cfg_wr(c, 7 * c); cfg_wr(c, -3); end
        set_base(0, 1000);
        for (int c = 1; c < NCH; c++) set_base(c, 64'(c) * 64'h1000);
        addr_out_ready = 0;
        ev(1, 0, 0, 0); ev(0, 1, 0, 0); ev(0, 1, 0, 1);
        repeat (3) ev(0, 0, 1, 1);
        ev(0, 0, 1, 0); ev(0, 1, 0, 1);
        repeat (3) ev(0, 0, 1, 1);
        for (int i = 0; i < 6; i++) chk("t1_model", mq[i][AW-1:0], t1[i]);
        addr_out_ready = 1;
        for (int i = 0; i < 6; i++) begin chk("t1_dut", addr_out[AW-1:0], t1[i]); tick(); end
        finish_nest();

        // Negative stride wrapping below zero.
        cfg_wr(0, -8);
        for (int c = 1; c < NCH; c++) cfg_wr(c, 1);
        set_base(0, 64'h10);
        addr_out_ready = 0;
        ev(1, 0, 0, 0); ev(0, 1, 0, 0);
        repeat (4) ev(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) chk("t2_model", mq[i][AW-1:0], t2[i]);
        addr_out_ready = 1;
        for (int i = 0; i < 4; i++) begin chk("t2_dut", addr_out[AW-1:0], t2[i]); tick(); end
        finish_nest();

        // Random three-level nests, all channels, random back-pressure, controller honours stall.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NCH; c++)
                for (int l = 0; l < 3; l++) cfg_wr(c, int'($urandom_range(0, 65535)));
            for (int c = 0; c < NCH; c++) set_base(c, {$urandom(), $urandom()});
            ev(1, 0, 0, 0); ev(0, 1, 0, 0);
            for (int k = 0; k < 80; k++) begin
                int p, lv;
                addr_out_ready = 1'($urandom_range(0, 1));
                p = int'($urandom_range(0, 9));
                lv = int'($urandom_range(0, 2));
                if (mq.size() >= DEP - 2) tick();
                else if (k == 40) ev(1, 0, 0, 0);
                else if (p < 2) tick();
                else if (p < 4) ev(0, 1, 0, lv);
                else if (p < 9) ev(0, 0, 1, lv);
                else ev(0, 1, 1, lv);
            end
            finish_nest();
        end

        // Fill with no consumer: stall at 6, overflow on the 9th push.
        for (int c = 0; c < NCH; c++) cfg_wr(c, c + 4);
        set_base(0, 64'h2000);
        addr_out_ready = 0;
        ev(1, 0, 0, 0); ev(0, 1, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            ev(0, 0, 1, 0);
            if (i == 5) chk("t4_stall_lo", loop_stall, 0);
            if (i == 6) chk("t4_stall_hi", loop_stall, 1);
            if (i == 8) chk("t4_ovf_lo", err_status[0], 0);
            if (i == 9) chk("t4_ovf_hi", err_status[0], 1);
        end
        chk("t4_depth", mq.size(), 8);
        addr_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_order", addr_out[AW-1:0], 64'h2000 + 64'(4 * i));
            tick();
        end
        chk("t4_empty", addr_out_valid, 0);

        // Config write while running is rejected.
        cfg_wr(0, 999);
        chk("t5_errcfg", err_status[1], 1);
        set_base(0, 64'h3000);
        ev(1, 0, 0, 0); ev(0, 1, 0, 0);
        ev(0, 0, 1, 0); chk("t5_a0", addr_out[AW-1:0], 64'h3000);
        ev(0, 0, 1, 0); chk("t5_a1", addr_out[AW-1:0], 64'h3004);
        finish_nest();
        chk("t5_idle", busy, 0);
        cfg_wr(0, 12);
        set_base(0, 64'h100);
        ev(1, 0, 0, 0); ev(0, 1, 0, 0);
        ev(0, 0, 1, 0); chk("t5_b0", addr_out[AW-1:0], 64'h100);
        ev(0, 0, 1, 0); chk("t5_b1", addr_out[AW-1:0], 64'h10C);
        finish_nest();

`ifdef MEM_WALKER_BOUND_CHECK_EN
        reset = 1; m_reset();
        @(posedge clk); #1;
        reset = 0;
        cfg_wr(0, 4);
        for (int c = 1; c < NCH; c++) cfg_wr(c, 0);
        base_addr = '0;
        cfg_addr_limit = '0;
        cfg_addr_limit[AW-1:0] = AW'(8);
        for (int c = 1; c < NCH; c++) cfg_addr_limit[c*AW +: AW] = AW'(64'hFFFF);
        addr_out_ready = 1;
        ev(1, 0, 0, 0); ev(0, 1, 0, 0);
        ev(0, 0, 1, 0); ev(0, 0, 1, 0);
        chk("t6_bnd_lo", err_status[2], 0);
        ev(0, 0, 1, 0);
        chk("t6_bnd_hi", err_status[2], 1);
        finish_nest();
        cfg_addr_limit = '1;
`endif

        // Asynchronous reset in the middle of a nest.
        for (int c = 0; c < NCH; c++) cfg_wr(c, 2);
        for (int c = 0; c < NCH; c++) set_base(c, {$urandom(), $urandom()});
        addr_out_ready = 0;
        ev(1, 0, 0, 0); ev(0, 1, 0, 0);
        repeat (3) ev(0, 0, 1, 0);
        cfg_wr(1, 5);
        reset = 1;
        #2;
        chk("ar_valid", addr_out_valid, 0);
        chk("ar_addr", addr_out, 0);
        chk("ar_stall", loop_stall, 0);
        chk("ar_busy", busy, 0);
        chk("ar_err", err_status, 0);
        m_reset();
        @(posedge clk); #1;
        reset = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
